rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (waddr/wdata/RegWrite) between NREQ

---
 rtl/rf_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module  : rf_wb_arbiter
// Purpose : Round-robin writeback arbiter for the single RF write port, with
//           a registered output stage and a pending-write (RAW) scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*AW-1:0] req_waddr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [AW-1:0]      waddr_o,
  output logic [DW-1:0]      wdata_o,
  output logic               RegWrite_o,
  input  logic               issue_valid_i,
  input  logic [AW-1:0]      issue_waddr_i,
  output logic               issue_ready_o,
  input  logic [AW-1:0]      raddr1_i,
  input  logic [AW-1:0]      raddr2_i,
  output logic               busy1_o,
  output logic               busy2_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 1 << AW;

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] idx_c;
  logic [PW-1:0] gidx_c;
  logic [NREQ-1:0] grant_c;
  logic          xfer_c;
  logic [AW-1:0] sel_waddr_c;
  logic [DW-1:0] sel_wdata_c;

  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          regwrite_q;

  logic [NR-1:0] busy_q, busy_d;
  logic          issue_fire_c;

  // Rotating priority: scan from rr_q upward, wrapping at NREQ.
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    idx_c   = '0;
    xfer_c  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_c = PW'((int'(rr_q) + k) % NREQ);
      if (!xfer_c && req_valid_i[idx_c]) begin
        grant_c[idx_c] = 1'b1;
        gidx_c         = idx_c;
        xfer_c         = 1'b1;
      end
    end
  end

  assign req_ready_o = grant_c;
  assign sel_waddr_c = req_waddr_i[int'(gidx_c)*AW +: AW];
  assign sel_wdata_c = req_wdata_i[int'(gidx_c)*DW +: DW];

  always_comb begin
    rr_d = rr_q;
    if (xfer_c) begin
      rr_d = (int'(gidx_c) == NREQ - 1) ? '0 : gidx_c + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      if (xfer_c) begin
        waddr_q    <= sel_waddr_c;
        wdata_q    <= sel_wdata_c;
        regwrite_q <= (sel_waddr_c != '0);
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign RegWrite_o = regwrite_q;

  assign issue_ready_o = (issue_waddr_i == '0) || !busy_q[issue_waddr_i];
  assign issue_fire_c  = issue_valid_i && issue_ready_o && (issue_waddr_i != '0);

  // Set is applied after clear so a same-edge issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (issue_fire_c) begin
      busy_d[issue_waddr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = busy_q[raddr1_i];
  assign busy2_o = busy_q[raddr2_i];

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module  : tb_rf_wb_arbiter
// Purpose : Directed, table-driven self-checking bench for rf_wb_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_waddr;
  logic [63:0] req_wdata;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        RegWrite;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        issue_ready;
  logic [4:0]  raddr1, raddr2;
  logic        busy1, busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_waddr_i  (req_waddr),
    .req_wdata_i  (req_wdata),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .RegWrite_o   (RegWrite),
    .issue_valid_i(issue_valid),
    .issue_waddr_i(issue_waddr),
    .issue_ready_o(issue_ready),
    .raddr1_i     (raddr1),
    .raddr2_i     (raddr2),
    .busy1_o      (busy1),
    .busy2_o      (busy2)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iv;
    logic [4:0]  iw;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [1:0]  e_rdy;
    logic        e_rw;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_ir;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(
      logic [1:0] valid, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1,
      logic [31:0] wd1, logic iv, logic [4:0] iw, logic [4:0] r1, logic [4:0] r2,
      logic [1:0] e_rdy, logic e_rw, logic [4:0] e_wa, logic [31:0] e_wd,
      logic e_ir, logic e_b1, logic e_b2);
    vec_t v;
    v.valid = valid; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.iw = iw; v.r1 = r1; v.r2 = r2;
    v.e_rdy = e_rdy; v.e_rw = e_rw; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_ir = e_ir; v.e_b1 = e_b1; v.e_b2 = e_b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid   = 2'b00;
    req_waddr   = '0;
    req_wdata   = '0;
    issue_valid = 1'b0;
    issue_waddr = '0;
    raddr1      = '0;
    raddr2      = '0;
  endtask

  initial begin
    // Registered outputs in row i reflect the transfer accepted during row i-1.
    //              valid wa0 wd0           wa1 wd1    iv iw r1 r2 | rdy  rw wa wd            ir b1 b2
    tbl[0]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0, 0, 0, 2'b00, 0, 0, 32'h0,        1, 0, 0);
    tbl[1]  = mk(2'b11, 1, 32'hA1,       2, 32'hB2, 0, 0, 0, 0, 2'b01, 0, 0, 32'h0,        1, 0, 0);
    tbl[2]  = mk(2'b11, 1, 32'hA1,       2, 32'hB2, 0, 0, 0, 0, 2'b10, 1, 1, 32'hA1,       1, 0, 0);
    tbl[3]  = mk(2'b11, 1, 32'hA1,       2, 32'hB2, 0, 0, 0, 0, 2'b01, 1, 2, 32'hB2,       1, 0, 0);
    tbl[4]  = mk(2'b11, 1, 32'hA1,       2, 32'hB2, 0, 0, 0, 0, 2'b10, 1, 1, 32'hA1,       1, 0, 0);
    tbl[5]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 32'h0,  0, 0, 0, 0, 2'b01, 1, 2, 32'hB2,       1, 0, 0);
    tbl[6]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0, 0, 0, 2'b00, 1, 5, 32'hDEADBEEF, 1, 0, 0);
    tbl[7]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0, 0, 0, 2'b00, 0, 5, 32'hDEADBEEF, 1, 0, 0);
    tbl[8]  = mk(2'b00, 0, 32'h0,        0, 32'h0,  1, 7, 7, 0, 2'b00, 0, 5, 32'hDEADBEEF, 1, 0, 0);
    tbl[9]  = mk(2'b10, 0, 32'h0,        7, 32'h77, 0, 7, 7, 0, 2'b10, 0, 5, 32'hDEADBEEF, 0, 1, 0);
    tbl[10] = mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 7, 7, 0, 2'b00, 1, 7, 32'h77,       0, 1, 0);
    tbl[11] = mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 7, 7, 0, 2'b00, 0, 7, 32'h77,       1, 0, 0);
    tbl[12] = mk(2'b01, 9, 32'h99,       0, 32'h0,  0, 0, 0, 9, 2'b01, 0, 7, 32'h77,       1, 0, 0);
    tbl[13] = mk(2'b00, 0, 32'h0,        0, 32'h0,  1, 9, 0, 9, 2'b00, 1, 9, 32'h99,       1, 0, 0);
    tbl[14] = mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 9, 0, 9, 2'b00, 0, 9, 32'h99,       0, 0, 1);
    tbl[15] = mk(2'b10, 0, 32'h0,        0, 32'h55, 0, 9, 0, 9, 2'b10, 0, 9, 32'h99,       0, 0, 1);
    tbl[16] = mk(2'b00, 0, 32'h0,        0, 32'h0,  1, 0, 0, 9, 2'b00, 0, 0, 32'h55,       1, 0, 1);
    tbl[17] = mk(2'b01, 3, 32'h33,       0, 32'h0,  0, 0, 0, 9, 2'b01, 0, 0, 32'h55,       1, 0, 1);

    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_regwrite", 32'(RegWrite), 32'd0);
    chk("reset_waddr", 32'(waddr), 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      req_valid   = tbl[i].valid;
      req_waddr   = {tbl[i].wa1, tbl[i].wa0};
      req_wdata   = {tbl[i].wd1, tbl[i].wd0};
      issue_valid = tbl[i].iv;
      issue_waddr = tbl[i].iw;
      raddr1      = tbl[i].r1;
      raddr2      = tbl[i].r2;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_regwrite", i), 32'(RegWrite), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tbl[i].e_wa));
      chk($sformatf("v%0d_wdata", i), wdata, tbl[i].e_wd);
      chk($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_busy1", i), 32'(busy1), 32'(tbl[i].e_b1));
      chk($sformatf("v%0d_busy2", i), 32'(busy2), 32'(tbl[i].e_b2));
      @(negedge clk);
    end

    // Write to $3 is in flight and $9 is still busy; reset must drop both.
    drive_idle();
    raddr2 = 5'd9;
    #1;
    chk("inflight_regwrite", 32'(RegWrite), 32'd1);
    chk("inflight_waddr", 32'(waddr), 32'd3);
    chk("inflight_busy9", 32'(busy2), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_regwrite", 32'(RegWrite), 32'd0);
    chk("midrst_waddr", 32'(waddr), 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    for (int r = 0; r < 32; r++) begin
      raddr1 = 5'(r);
      raddr2 = 5'(31 - r);
      #1;
      chk($sformatf("midrst_busy1_r%0d", r), 32'(busy1), 32'd0);
      chk($sformatf("midrst_busy2_r%0d", 31 - r), 32'(busy2), 32'd0);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b11;
    req_waddr = {5'd2, 5'd1};
    #1;
    chk("postrst_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("postrst_grant2", 32'(req_ready), 32'd2);
    chk("postrst_regwrite", 32'(RegWrite), 32'd1);
    chk("postrst_waddr", 32'(waddr), 32'd1);
    drive_idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
